// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch instruction assembler
package fetch_pkg;

   // Assembler FSM: waiting for an opcode word, or collecting immediate words.
   typedef enum logic {
      S_OP  = 1'b0,
      S_IMM = 1'b1
   } fetch_state_e;

   localparam int WORD_W_DEF  = 16;
   localparam int IMM_BIT_DEF = 2;

   // Width of the consumed-word count, shared with the PC-increment logic.
   localparam int LEN_W = 3;

endpackage

// File: rtl/fetch_instr_assembler.sv
// rtl/fetch_instr_assembler.sv - assembles opcode plus optional immediate words into one instruction
module fetch_instr_assembler
   import fetch_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int IMM_BIT   = IMM_BIT_DEF,
   parameter int IMM_WORDS = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [WORD_W-1:0]           in_word,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WORD_W-1:0]           out_instr,
   output logic [IMM_WORDS*WORD_W-1:0] out_imm,
   output logic                        out_has_imm,
   output logic [LEN_W-1:0]            out_len
);

   // Parameter sanity: the 2-bit counter covers at most four immediate words.
   if (IMM_WORDS < 1 || IMM_WORDS > 4) begin : g_bad_imm_words
      $error("fetch_instr_assembler: IMM_WORDS must be in 1..4");
   end
   if (IMM_BIT >= WORD_W) begin : g_bad_imm_bit
      $error("fetch_instr_assembler: IMM_BIT must be below WORD_W");
   end

   localparam logic [1:0]       IMM_LAST = 2'(IMM_WORDS - 1);
   localparam logic [LEN_W-1:0] LEN_IMM  = LEN_W'(1 + IMM_WORDS);
   localparam logic [LEN_W-1:0] LEN_OP   = LEN_W'(1);

   fetch_state_e                state_q;
   logic [1:0]                  imm_cnt_q;
   logic [WORD_W-1:0]           hold_q;
   logic                        out_valid_q;
   logic [WORD_W-1:0]           out_instr_q;
   logic [IMM_WORDS*WORD_W-1:0] out_imm_q;
   logic                        out_has_imm_q;
   logic [LEN_W-1:0]            out_len_q;

   // Accumulator contents including the word arriving this cycle in slot imm_cnt.
   logic [IMM_WORDS*WORD_W-1:0] imm_full_d;

   logic xfer;
   logic handoff;
   logic op_with_imm;
   logic imm_write;

   // The input side only stalls on flush or a held output; never depends on in_word.
   always_comb begin
      in_ready = !flush && (!out_valid_q || out_ready);
   end

   assign xfer        = in_valid && in_ready;
   assign handoff     = out_valid_q && out_ready;
   assign op_with_imm = xfer && (state_q == S_OP) && in_word[IMM_BIT];
   assign imm_write   = xfer && (state_q == S_IMM);

   // One register per immediate slot; the opcode of a new immediate instruction clears them.
   for (genvar g = 0; g < IMM_WORDS; g++) begin : g_acc
      logic [WORD_W-1:0] slot_q;

      // Slot g captures the immediate word that arrives while imm_cnt points at it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_q <= '0;
         end else if (op_with_imm) begin
            slot_q <= '0;
         end else if (imm_write && (imm_cnt_q == 2'(g))) begin
            slot_q <= in_word;
         end
      end

      assign imm_full_d[g*WORD_W +: WORD_W] = (imm_cnt_q == 2'(g)) ? in_word : slot_q;
   end

   // Assembler FSM with registered output stage; flush outranks every transfer and handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_OP;
         imm_cnt_q     <= 2'd0;
         hold_q        <= '0;
         out_valid_q   <= 1'b0;
         out_instr_q   <= '0;
         out_imm_q     <= '0;
         out_has_imm_q <= 1'b0;
         out_len_q     <= '0;
      end else if (flush) begin
         state_q     <= S_OP;
         imm_cnt_q   <= 2'd0;
         out_valid_q <= 1'b0;
      end else begin
         if (handoff) begin
            out_valid_q <= 1'b0;
         end
         if (xfer) begin
            case (state_q)
               S_OP: begin
                  if (in_word[IMM_BIT]) begin
                     hold_q    <= in_word;
                     imm_cnt_q <= 2'd0;
                     state_q   <= S_IMM;
                  end else begin
                     out_instr_q   <= in_word;
                     out_imm_q     <= '0;
                     out_has_imm_q <= 1'b0;
                     out_len_q     <= LEN_OP;
                     out_valid_q   <= 1'b1;
                  end
               end
               S_IMM: begin
                  if (imm_cnt_q == IMM_LAST) begin
                     out_instr_q   <= hold_q;
                     out_imm_q     <= imm_full_d;
                     out_has_imm_q <= 1'b1;
                     out_len_q     <= LEN_IMM;
                     out_valid_q   <= 1'b1;
                     imm_cnt_q     <= 2'd0;
                     state_q       <= S_OP;
                  end else begin
                     imm_cnt_q <= imm_cnt_q + 2'd1;
                  end
               end
               default: begin
                  state_q <= S_OP;
               end
            endcase
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_imm     = out_imm_q;
   assign out_has_imm = out_has_imm_q;
   assign out_len     = out_len_q;

endmodule

// File: tb/tb_fetch_instr_assembler.sv
// tb/tb_fetch_instr_assembler.sv - scoreboard bench for fetch_instr_assembler
module tb_fetch_instr_assembler;
   import fetch_pkg::*;

   typedef struct {
      logic [15:0] instr;
      logic [63:0] imm;
      logic        has;
      logic [2:0]  len;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   // DUT A: two immediate words
   logic        a_in_valid = 1'b0;
   logic [15:0] a_in_word = '0;
   logic        a_in_ready;
   logic        a_flush = 1'b0;
   logic        a_out_valid;
   logic        a_out_ready = 1'b1;
   logic [15:0] a_out_instr;
   logic [31:0] a_out_imm;
   logic        a_out_has_imm;
   logic [2:0]  a_out_len;

   // DUT B: one immediate word
   logic        b_in_valid = 1'b0;
   logic [15:0] b_in_word = '0;
   logic        b_in_ready;
   logic        b_flush = 1'b0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic [15:0] b_out_instr;
   logic [15:0] b_out_imm;
   logic        b_out_has_imm;
   logic [2:0]  b_out_len;

   exp_t qa[$];
   exp_t qb[$];
   int   hs[$];
   int   hsb[$];
   exp_t ea;
   exp_t eb;
   int   t_acc;

   fetch_instr_assembler #(.WORD_W(16), .IMM_BIT(2), .IMM_WORDS(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_word(a_in_word),
      .in_ready(a_in_ready), .flush(a_flush), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_instr(a_out_instr), .out_imm(a_out_imm),
      .out_has_imm(a_out_has_imm), .out_len(a_out_len)
   );

   fetch_instr_assembler #(.WORD_W(16), .IMM_BIT(2), .IMM_WORDS(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_word(b_in_word),
      .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_instr(b_out_instr), .out_imm(b_out_imm),
      .out_has_imm(b_out_has_imm), .out_len(b_out_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor A: pop the expected instruction at every accepted output
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready && !a_flush) begin
         hs.push_back(cyc);
         if (qa.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL a_unexpected: got instr %0h expected no output", a_out_instr);
         end else begin
            ea = qa.pop_front();
            chk("a_instr", 64'(a_out_instr), 64'(ea.instr));
            chk("a_imm", 64'(a_out_imm), ea.imm);
            chk("a_has_imm", 64'(a_out_has_imm), 64'(ea.has));
            chk("a_len", 64'(a_out_len), 64'(ea.len));
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready && !b_flush) begin
         hsb.push_back(cyc);
         if (qb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL b_unexpected: got instr %0h expected no output", b_out_instr);
         end else begin
            eb = qb.pop_front();
            chk("b_instr", 64'(b_out_instr), 64'(eb.instr));
            chk("b_imm", 64'(b_out_imm), eb.imm);
            chk("b_has_imm", 64'(b_out_has_imm), 64'(eb.has));
            chk("b_len", 64'(b_out_len), 64'(eb.len));
         end
      end
   end

   function automatic exp_t mk(input logic [15:0] i, input logic [63:0] m, input logic h,
                               input logic [2:0] l);
      exp_t e;
      e.instr = i;
      e.imm   = m;
      e.has   = h;
      e.len   = l;
      return e;
   endfunction

   // Present one word to DUT A until accepted; returns at posedge+1 of the accepting edge.
   task automatic send_a(input logic [15:0] w);
      logic acc;
      int   n;
      a_in_valid = 1'b1;
      a_in_word  = w;
      n = 0;
      do begin
         @(negedge clk);
         acc = a_in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL a_send_timeout: got no accept expected accept of %0h", w);
      end
      t_acc = cyc;
      a_in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      #23 rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Reset state
      @(negedge clk);
      chk("reset_out_valid", 64'(a_out_valid), 64'd0);
      chk("reset_out_len", 64'(a_out_len), 64'd0);
      chk("reset_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Back-to-back plain opcodes, one output per cycle
      hs.delete();
      qa.push_back(mk(16'h0001, 64'h0, 1'b0, 3'd1));
      qa.push_back(mk(16'h0010, 64'h0, 1'b0, 3'd1));
      qa.push_back(mk(16'h0020, 64'h0, 1'b0, 3'd1));
      send_a(16'h0001);
      t0 = t_acc;
      send_a(16'h0010);
      send_a(16'h0020);
      idle(3);
      chk("plain_count", 64'(hs.size()), 64'd3);
      if (hs.size() == 3) begin
         chk("plain_latency", 64'(hs[0]), 64'(t0));
         chk("plain_gap1", 64'(hs[1] - hs[0]), 64'd1);
         chk("plain_gap2", 64'(hs[2] - hs[1]), 64'd1);
      end

      // IMM_WORDS=1 on DUT B: 0x0004 then 0xBEEF
      hsb.delete();
      qb.push_back(mk(16'h0004, 64'h0000_BEEF, 1'b1, 3'd2));
      b_in_valid = 1'b1;
      b_in_word  = 16'h0004;
      @(posedge clk);
      #1;
      b_in_word = 16'hBEEF;
      @(posedge clk);
      #1;
      t0 = cyc;
      b_in_valid = 1'b0;
      idle(3);
      chk("b_count", 64'(hsb.size()), 64'd1);
      if (hsb.size() == 1) chk("b_latency", 64'(hsb[0]), 64'(t0));

      // IMM_WORDS=2 with input gaps; immediate 0x0004 is not an opcode
      hs.delete();
      qa.push_back(mk(16'h0004, 64'h0004_1234, 1'b1, 3'd3));
      send_a(16'h0004);
      idle(3);
      send_a(16'h1234);
      idle(3);
      send_a(16'h0004);
      t0 = t_acc;
      qa.push_back(mk(16'h0008, 64'h0, 1'b0, 3'd1));
      send_a(16'h0008);
      idle(3);
      chk("imm2_count", 64'(hs.size()), 64'd2);
      if (hs.size() == 2) chk("imm2_latency", 64'(hs[0]), 64'(t0));

      // Back-pressure: output held 5 cycles, then handoff and accept in one cycle
      a_out_ready = 1'b0;
      qa.push_back(mk(16'h0011, 64'h0, 1'b0, 3'd1));
      qa.push_back(mk(16'h0022, 64'h0, 1'b0, 3'd1));
      send_a(16'h0011);
      a_in_valid = 1'b1;
      a_in_word  = 16'h0022;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_in_ready", 64'(a_in_ready), 64'd0);
         chk("hold_out_valid", 64'(a_out_valid), 64'd1);
         chk("hold_out_instr", 64'(a_out_instr), 64'h0011);
      end
      @(posedge clk);
      #1;
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      idle(3);

      // Flush mid-immediate: partial instruction discarded
      send_a(16'h0004);
      send_a(16'h1111);
      a_flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(a_in_ready), 64'd0);
      @(posedge clk);
      #1;
      a_flush = 1'b0;
      qa.push_back(mk(16'h0001, 64'h0, 1'b0, 3'd1));
      send_a(16'h0001);
      idle(3);

      // Flush while an output is presented with out_ready=1: output dropped
      send_a(16'h0033);
      a_flush = 1'b1;
      @(posedge clk);
      #1;
      a_flush = 1'b0;
      @(negedge clk);
      chk("flush_drop_valid", 64'(a_out_valid), 64'd0);
      idle(2);

      // Asynchronous reset mid-immediate
      send_a(16'h0004);
      send_a(16'h5555);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(a_out_valid), 64'd0);
      chk("arst_out_instr", 64'(a_out_instr), 64'd0);
      chk("arst_out_imm", 64'(a_out_imm), 64'd0);
      chk("arst_out_has_imm", 64'(a_out_has_imm), 64'd0);
      chk("arst_out_len", 64'(a_out_len), 64'd0);
      idle(2);
      #2 rst_n = 1'b1;
      idle(1);
      qa.push_back(mk(16'h0001, 64'h0, 1'b0, 3'd1));
      send_a(16'h0001);
      idle(4);

      chk("a_queue_drained", 64'(qa.size()), 64'd0);
      chk("b_queue_drained", 64'(qb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
